pe_accumulator: RTL and testbench

//   Consumer side of the 8-lane PE dot-product pipeline. Tracks which PE output

---
 rtl/pe_accumulator.sv | 186 ++++++++++++++++++
 tb/tb_pe_accumulator.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_accumulator.sv
`timescale 1ns / 1ps
// pe_accumulator: consumer side of the 8-lane PE dot-product pipeline.
//   A shadow valid pipe (tag) follows operands through the PE so the block knows
//   which pe_out words are real partials. For each neuron it sums num_chunks
//   partials onto the bias, then applies optional ReLU and signed saturation, and
//   presents one result on a valid/ready port. stall freezes the PE while a result
//   is held, so no partial can be lost.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   clr               synchronous flush (same cycle as PE clr)
//   pe_en             PE enable as applied to the PE this cycle
//   pe_in_valid       operands entering the PE this cycle are a real chunk
//   pe_out            PE result register
//   start             begin neuron (latches num_chunks, bias, relu_en)
//   num_chunks        partials to sum for this neuron
//   bias              neuron bias
//   relu_en           clamp negative result to 0
//   out_data/out_valid/out_ready   result handshake
//   stall             out_valid & ~out_ready, gates the PE enable upstream
//   busy              a neuron is being accumulated
//   overrun           sticky: a valid partial arrived while idle
module pe_accumulator #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned PE_LAT = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             pe_en,
  input  logic             pe_in_valid,
  input  logic [WIDTH-1:0] pe_out,
  input  logic             start,
  input  logic [CNT_W-1:0] num_chunks,
  input  logic [WIDTH-1:0] bias,
  input  logic             relu_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stall,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned ACC_W = WIDTH + CNT_W;

  // Saturation bounds expressed in accumulator width.
  localparam logic signed [ACC_W-1:0] SatMax = {{(CNT_W + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(CNT_W + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                   state_q, state_d;
  logic [PE_LAT-1:0]        tag_q, tag_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         num_q, num_d;
  logic                     relu_q, relu_d;
  logic [WIDTH-1:0]         out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  logic                     accept;
  logic                     fin;
  logic                     fin_relu;
  logic signed [ACC_W-1:0]  fin_val;
  logic signed [ACC_W-1:0]  sum;

  function automatic logic signed [ACC_W-1:0] sext(input logic [WIDTH-1:0] x);
    return {{CNT_W{x[WIDTH-1]}}, x};
  endfunction

  function automatic logic [WIDTH-1:0] relu_sat(input logic signed [ACC_W-1:0] v,
                                                input logic relu);
    logic signed [ACC_W-1:0] r;
    r = (relu && v < 0) ? '0 : v;
    if (r > SatMax) begin
      return {1'b0, {(WIDTH - 1){1'b1}}};
    end else if (r < SatMin) begin
      return {1'b1, {(WIDTH - 1){1'b0}}};
    end
    return r[WIDTH-1:0];
  endfunction

  assign accept    = tag_q[PE_LAT-1] & pe_en;
  assign stall     = out_valid_q & ~out_ready;
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

  always_comb begin
    state_d     = state_q;
    tag_d       = pe_en ? {tag_q[PE_LAT-2:0], pe_in_valid} : tag_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    relu_d      = relu_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    fin         = 1'b0;
    fin_relu    = relu_q;
    fin_val     = '0;
    sum         = acc_q + sext(pe_out);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // A partial while idle has no neuron to belong to; flag and drop it.
        if (accept) begin
          overrun_d = 1'b1;
        end
        if (start && !stall) begin
          acc_d  = sext(bias);
          cnt_d  = '0;
          num_d  = num_chunks;
          relu_d = relu_en;
          if (num_chunks == '0) begin
            fin      = 1'b1;
            fin_val  = sext(bias);
            fin_relu = relu_en;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == num_q - CNT_W'(1)) begin
            fin     = 1'b1;
            fin_val = sum;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A new result wins over a same-cycle handshake, so out_valid stays high.
    if (fin) begin
      out_valid_d = 1'b1;
      out_data_d  = relu_sat(fin_val, fin_relu);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      num_q       <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (clr) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      num_q       <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      relu_q      <= relu_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_pe_accumulator.sv
`timescale 1ns / 1ps
// Bench for pe_accumulator: a delay-line PE model feeds partials, expected neuron
// results are pushed when each neuron starts, and a monitor pops and compares on
// every output transfer.
module tb_pe_accumulator;
  localparam int W = 16;
  localparam int L = 5;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst, clr, pe_en, pe_in_valid, start, relu_en;
  logic         out_ready = 1'b1;
  logic         out_valid, stall, busy, overrun;
  logic [W-1:0] pe_out, bias, out_data, pe_data;
  logic [C-1:0] num_chunks;
  logic [W-1:0] pipe [L];

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q [$];
  int           cyc = 0;
  int           rise_cyc = 0;
  int           last_feed_cyc = 0;
  logic         ov_prev = 1'b0;
  bit           ready_rand = 1'b0;
  logic         ready_val = 1'b1;

  always #5 clk = ~clk;

  pe_accumulator #(.WIDTH(W), .PE_LAT(L), .CNT_W(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .pe_en      (pe_en),
    .pe_in_valid(pe_in_valid),
    .pe_out     (pe_out),
    .start      (start),
    .num_chunks (num_chunks),
    .bias       (bias),
    .relu_en    (relu_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .stall      (stall),
    .busy       (busy),
    .overrun    (overrun)
  );

  // PE stand-in: an enable-gated delay line of L stages.
  assign pe_out = pipe[L-1];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pe_en) begin
      pipe[0] <= pe_data;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_rand ? ($urandom_range(3) != 0) : ready_val;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) rise_cyc = cyc;
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h expected none", out_data);
      end else begin
        check("result", out_data, exp_q.pop_front());
      end
    end
  end

  function automatic logic [W-1:0] model(input int s, input bit relu);
    int r;
    r = (relu && s < 0) ? 0 : s;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[W-1:0];
  endfunction

  // One PE issue slot; gaps drop pe_en (pe_in_valid is then don't-care).
  task automatic feed(input bit v, input logic [W-1:0] d, input int gap_pct);
    int guard = 0;
    bit en;
    forever begin
      if (guard++ > 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL feed_timeout: got stalled expected progress");
        return;
      end
      pe_data = d;
      if ($urandom_range(99) < gap_pct) begin
        pe_en       = 1'b0;
        pe_in_valid = 1'($urandom_range(1));
        @(negedge clk);
      end else begin
        pe_in_valid = v;
        en          = !(out_valid && !out_ready);
        pe_en       = en;
        @(negedge clk);
        if (en) begin
          if (v) last_feed_cyc = cyc;
          break;
        end
      end
    end
    pe_en       = 1'b0;
    pe_in_valid = 1'b0;
  endtask

  task automatic wait_startable();
    int guard = 0;
    @(negedge clk);
    while (busy || (out_valid && !out_ready)) begin
      if (guard++ > 500) begin
        n_cmp++;
        n_bad++;
        $display("FAIL start_timeout: got busy expected idle");
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic neuron(input logic [W-1:0] b, input int num, input bit relu,
                        input logic [W-1:0] parts [$], input int gap_pct, input int hold_at);
    int s;
    s = $signed(b);
    foreach (parts[i]) s += $signed(parts[i]);
    wait_startable();
    start      = 1'b1;
    bias       = b;
    num_chunks = C'(num);
    relu_en    = relu;
    exp_q.push_back(model(s, relu));
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < num; i++) begin
      if (i == hold_at) begin
        repeat (3) begin
          pe_en       = 1'b0;
          pe_in_valid = 1'b1;
          pe_data     = 16'hDEAD;
          @(negedge clk);
        end
      end
      feed(1'b1, parts[i], gap_pct);
    end
    if (num > 0) for (int i = 0; i < L; i++) feed(1'b0, '0, gap_pct);
  endtask

  task automatic drain();
    int guard = 0;
    while (out_valid || exp_q.size() != 0) begin
      if (guard++ > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [W-1:0] p [$];
    int           nn;
    rst = 1'b1; clr = 1'b0; pe_en = 1'b0; pe_in_valid = 1'b0; pe_data = '0;
    start = 1'b0; num_chunks = '0; bias = '0; relu_en = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic sum with continuous enable, plus result latency after the last chunk.
    p = '{16'h0100, 16'h0200, 16'h0300};
    neuron(16'h0010, 3, 1'b0, p, 0, -1);
    @(negedge clk);
    check("latency_cycles", rise_cyc - last_feed_cyc, 5);
    drain();

    p = '{16'hFF00, 16'hFF00};
    neuron(16'h0000, 2, 1'b1, p, 0, -1);
    neuron(16'h0000, 2, 1'b0, p, 0, -1);
    p = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
    neuron(16'h0000, 4, 1'b0, p, 0, -1);
    p = '{16'h9000, 16'h9000, 16'h9000, 16'h9000};
    neuron(16'h0000, 4, 1'b0, p, 0, -1);
    // Enable held low mid-stream with pe_in_valid high must not double count.
    p = '{16'h0100, 16'h0200, 16'h0300};
    neuron(16'h0010, 3, 1'b0, p, 0, 1);
    drain();

    // Held output: stall asserted, data steady, then exactly one transfer.
    ready_val = 1'b0;
    @(negedge clk);
    neuron(16'h0010, 3, 1'b0, p, 0, -1);
    for (int i = 0; i < 10; i++) begin
      check("held_stall", stall, 1);
      check("held_data", out_data, 16'h0610);
      @(negedge clk);
    end
    ready_val = 1'b1;
    drain();
    @(negedge clk);
    check("after_xfer_valid", out_valid, 0);

    // Zero chunks: bias appears the cycle after start.
    wait_startable();
    start = 1'b1; bias = 16'h0042; num_chunks = '0; relu_en = 1'b0;
    exp_q.push_back(16'h0042);
    @(negedge clk);
    start = 1'b0;
    check("num0_valid", out_valid, 1);
    check("num0_data", out_data, 16'h0042);
    check("num0_busy", busy, 0);
    drain();

    // Reset in the middle of a neuron discards it.
    wait_startable();
    start = 1'b1; bias = 16'h0005; num_chunks = 8'd3; relu_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    feed(1'b1, 16'h0011, 0);
    feed(1'b0, '0, 0);
    check("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Partial while idle sets overrun; clr clears it and flushes in-flight tags.
    feed(1'b1, 16'h1234, 0);
    for (int i = 0; i < L; i++) feed(1'b0, '0, 0);
    check("overrun_set", overrun, 1);
    check("overrun_no_out", out_valid, 0);
    feed(1'b1, 16'h1234, 0);
    feed(1'b0, '0, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_overrun", overrun, 0);
    for (int i = 0; i < L; i++) feed(1'b0, '0, 0);
    check("clr_flush_overrun", overrun, 0);

    // Randomized neurons with random enable gaps and random output backpressure.
    ready_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bit big;
      big = 1'($urandom_range(1));
      nn  = $urandom_range(6);
      p.delete();
      for (int i = 0; i < nn; i++)
        p.push_back(big ? W'($urandom) : W'($urandom_range(1023) - 512));
      neuron(big ? W'($urandom) : W'($urandom_range(255) - 128), nn,
             1'($urandom_range(1)), p, 20, -1);
    end
    ready_rand = 1'b0;
    ready_val  = 1'b1;
    drain();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
